// File: rtl/card_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : card_pkg
//  Description : Shared card-array types, LFSR constants and shuffle states.
//  Revision    : 1.0 - initial release
// ============================================================================
package card_pkg;

    localparam int N_CARDS = 16;
    localparam int CARD_W  = 5;
    localparam int IDX_W   = 4;

    localparam logic [15:0] LFSR_MASK    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    typedef logic [CARD_W-1:0]     card_t;
    typedef card_t [0:N_CARDS-1]   card_arr_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PICK = 2'd1,
        SWAP = 2'd2,
        DONE = 2'd3
    } shuf_state_t;

    // Right-shifting Galois step for x^16+x^14+x^13+x^11.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_MASK : 16'h0000);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr16.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr16
//  Description : Free-running 16-bit Galois LFSR with zero-lockup recovery.
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr16
    import card_pkg::*;
#(
    parameter logic [15:0] SEED = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] q
);

    logic [15:0] r_q;

    // An all-zero state would stick forever, so it is replaced by the seed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= SEED;
        end else if (r_q == 16'h0000) begin
            r_q <= SEED;
        end else begin
            r_q <= lfsr_step(r_q);
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/card_shuffler.sv
`default_nettype none
// ============================================================================
//  Module      : card_shuffler
//  Description : In-place Fisher-Yates shuffle of the card array, LFSR driven.
//  Revision    : 1.0 - initial release
// ============================================================================
module card_shuffler
    import card_pkg::*;
#(
    parameter int          N_CARDS   = card_pkg::N_CARDS,
    parameter int          CARD_W    = card_pkg::CARD_W,
    parameter int          IDX_W     = card_pkg::IDX_W,
    parameter logic [15:0] SEED      = DEFAULT_SEED,
    parameter int          MAX_TRIES = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CARD_W-1:0] arr_in  [0:N_CARDS-1],
    output logic [CARD_W-1:0] arr_out [0:N_CARDS-1],
    output logic              busy,
    output logic              load,
    output logic              done
);

    localparam int               TRY_W      = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [TRY_W-1:0] C_TRY_LAST = TRY_W'(MAX_TRIES - 1);
    localparam logic [IDX_W-1:0] C_I_FIRST  = IDX_W'(N_CARDS - 1);
    localparam logic [IDX_W-1:0] C_I_LAST   = IDX_W'(1);

    shuf_state_t       r_state;
    shuf_state_t       w_state_nxt;
    logic [15:0]       w_lfsr;
    logic [IDX_W-1:0]  w_r;
    logic              w_r_ok;
    logic              w_unused_lfsr;
    logic [IDX_W-1:0]  r_i;
    logic [IDX_W-1:0]  r_j;
    logic [TRY_W-1:0]  r_tries;
    logic [CARD_W-1:0] r_work    [0:N_CARDS-1];
    logic [CARD_W-1:0] w_swapped [0:N_CARDS-1];
    logic              r_busy;
    logic              r_load;
    logic              r_done;

    lfsr16 #(.SEED(SEED)) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (w_lfsr)
    );

    assign w_r           = w_lfsr[IDX_W-1:0];
    assign w_r_ok        = (w_r <= r_i);
    assign w_unused_lfsr = &{1'b0, w_lfsr[15:IDX_W]};

    // Work array with entries i and j exchanged; i == j is a harmless no-op.
    always_comb begin
        for (int k = 0; k < N_CARDS; k++) begin
            w_swapped[k] = r_work[k];
        end
        w_swapped[r_i] = r_work[r_j];
        w_swapped[r_j] = r_work[r_i];
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = PICK;
            PICK:    if (w_r_ok || (r_tries == C_TRY_LAST)) w_state_nxt = SWAP;
            SWAP:    w_state_nxt = (r_i == C_I_LAST) ? DONE : PICK;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_i     <= C_I_FIRST;
            r_j     <= '0;
            r_tries <= '0;
            r_busy  <= 1'b0;
            r_load  <= 1'b0;
            r_done  <= 1'b0;
            for (int k = 0; k < N_CARDS; k++) begin
                r_work[k]  <= '0;
                arr_out[k] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_load  <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        for (int k = 0; k < N_CARDS; k++) begin
                            r_work[k] <= arr_in[k];
                        end
                        r_i     <= C_I_FIRST;
                        r_tries <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                PICK: begin
                    if (w_r_ok) begin
                        r_j <= w_r;
                    end else if (r_tries == C_TRY_LAST) begin
                        r_j <= r_i;
                    end else begin
                        r_tries <= r_tries + TRY_W'(1);
                    end
                end
                SWAP: begin
                    for (int k = 0; k < N_CARDS; k++) begin
                        r_work[k] <= w_swapped[k];
                    end
                    r_tries <= '0;
                    // Final swap publishes straight to arr_out so it is valid with load.
                    if (r_i == C_I_LAST) begin
                        for (int k = 0; k < N_CARDS; k++) begin
                            arr_out[k] <= w_swapped[k];
                        end
                        r_load <= 1'b1;
                        r_done <= 1'b1;
                    end else begin
                        r_i <= r_i - IDX_W'(1);
                    end
                end
                DONE: begin
                    r_busy <= 1'b0;
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign load = r_load;
    assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_card_shuffler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_card_shuffler
//  Description : Scoreboard bench for card_shuffler with an LFSR golden model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_card_shuffler;
    import card_pkg::*;

    logic       clk    = 1'b0;
    logic       rst    = 1'b0;
    logic       start  = 1'b0;
    logic       start1 = 1'b0;
    logic [4:0] arr_in   [0:15];
    logic [4:0] arr_out  [0:15];
    logic [4:0] arr_in1  [0:15];
    logic [4:0] arr_out1 [0:15];
    logic       busy, load, done;
    logic       busy1, load1, done1;

    always #10 clk = ~clk;

    card_shuffler dut (
        .clk(clk), .rst(rst), .start(start), .arr_in(arr_in), .arr_out(arr_out),
        .busy(busy), .load(load), .done(done)
    );

    card_shuffler #(.MAX_TRIES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .arr_in(arr_in1), .arr_out(arr_out1),
        .busy(busy1), .load(load1), .done(done1)
    );

    typedef struct {
        card_arr_t arr;
        card_arr_t src;
        int        lat;
        int        acc;
        bit        gold;
    } exp_t;

    exp_t      q0[$];
    exp_t      q1[$];
    exp_t      e0, e1;
    int        total = 0;
    int        bad = 0;
    int        cyc = 0;
    int        done_cnt = 0;
    int        done_cnt1 = 0;
    int        lat0, lat1;
    card_arr_t last0;
    card_arr_t ident;
    logic [15:0] m_lfsr;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model_step(input logic [15:0] s);
        logic [15:0] n;
        if (s == 16'h0) return 16'hACE1;
        n = {1'b0, s[15:1]};
        if (s[0]) n = n ^ 16'hB400;
        return n;
    endfunction

    function automatic card_arr_t pack(input logic [4:0] a [0:15]);
        card_arr_t p;
        for (int k = 0; k < 16; k++) p[k] = a[k];
        return p;
    endfunction

    function automatic bit perm_ok(input card_arr_t a, input card_arr_t b);
        int cnt [0:31];
        for (int v = 0; v < 32; v++) cnt[v] = 0;
        for (int k = 0; k < 16; k++) begin
            cnt[a[k]]++;
            cnt[b[k]]--;
        end
        for (int v = 0; v < 32; v++) if (cnt[v] != 0) return 1'b0;
        return 1'b1;
    endfunction

    // l0 is the LFSR value seen by the first PICK decision.
    function automatic void golden(input card_arr_t a, input logic [15:0] l0, input int maxt,
                                   output card_arr_t res, output int lat);
        logic [15:0] l;
        int          edges, j, r, tries;
        card_t       t;
        l     = l0;
        edges = 0;
        res   = a;
        for (int i = 15; i >= 1; i--) begin
            tries = 0;
            j     = -1;
            while (j < 0) begin
                r = int'(l[3:0]);
                l = model_step(l);
                edges++;
                if (r <= i) j = r;
                else if (tries < maxt - 1) tries++;
                else j = i;
            end
            t      = res[i];
            res[i] = res[j];
            res[j] = t;
            l      = model_step(l);
            edges++;
        end
        lat = edges + 2;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) m_lfsr <= 16'hACE1;
        else      m_lfsr <= model_step(m_lfsr);
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done || load) chk("load_eq_done", load, done);
        if (done) begin
            done_cnt++;
            last0 = pack(arr_out);
            if (q0.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e0   = q0.pop_front();
                lat0 = cyc - e0.acc + 1;
                chk("permutation", perm_ok(last0, e0.src), 1);
                chk("lat_range", (lat0 >= 32 && lat0 <= 137), 1);
                if (e0.gold) begin
                    chk("golden_arr", last0, e0.arr);
                    chk("latency", lat0, e0.lat);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (done1 || load1) chk("load1_eq_done1", load1, done1);
        if (done1) begin
            done_cnt1++;
            if (q1.size() == 0) begin
                chk("unexpected_done1", 1, 0);
            end else begin
                e1   = q1.pop_front();
                lat1 = cyc - e1.acc + 1;
                chk("permutation1", perm_ok(pack(arr_out1), e1.src), 1);
                chk("lat1_le32", lat1 <= 32, 1);
                chk("golden_arr1", pack(arr_out1), e1.arr);
            end
        end
    end

    task automatic run_start(input int sel, input card_arr_t a, input bit gold);
        exp_t e;
        int   acc;
        int   guard;
        guard = 0;
        @(negedge clk);
        while (((sel == 0) ? busy : busy1) && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 300) chk("idle_timeout", 0, 1);
        for (int k = 0; k < 16; k++) begin
            if (sel == 0) arr_in[k] = a[k];
            else          arr_in1[k] = a[k];
        end
        if (sel == 0) start = 1'b1;
        else          start1 = 1'b1;
        acc = cyc;
        @(negedge clk);
        start  = 1'b0;
        start1 = 1'b0;
        for (int k = 0; k < 16; k++) begin
            arr_in[k]  = 5'($urandom);
            arr_in1[k] = 5'($urandom);
        end
        chk("busy_after_start", (sel == 0) ? busy : busy1, 1);
        e.src  = a;
        e.gold = gold;
        e.acc  = acc;
        golden(a, m_lfsr, (sel == 0) ? 8 : 1, e.arr, e.lat);
        if (sel == 0) q0.push_back(e);
        else          q1.push_back(e);
    endtask

    task automatic wait_done(input int sel, input int base);
        int n;
        n = 0;
        while (((sel == 0) ? done_cnt : done_cnt1) == base && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("done_timeout", 0, 1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        card_arr_t src;
        logic [4:0] x;
        int base;
        for (int k = 0; k < 16; k++) begin
            ident[k]   = 5'(k);
            arr_in[k]  = '0;
            arr_in1[k] = '0;
        end

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_load", load, 0);
        chk("rst_done", done, 0);
        chk("rst_arr_out", pack(arr_out), 0);
        chk("rst_arr_out1", pack(arr_out1), 0);
        rst = 1'b1;

        // Identity input.
        base = done_cnt;
        run_start(0, ident, 1'b1);
        wait_done(0, base);
        chk("one_done", done_cnt - base, 1);
        chk("not_identity", last0 != ident, 1);

        // Second start 5 cycles into a shuffle is ignored.
        base = done_cnt;
        run_start(0, ident, 1'b1);
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(0, base);
        repeat (40) @(negedge clk);
        chk("second_start_ignored", done_cnt - base, 1);

        // Random data, random gaps.
        for (int n = 0; n < 100; n++) begin
            x = 5'($urandom_range(0, 31));
            for (int k = 0; k < 16; k++) src[k] = 5'(k) ^ x;
            repeat ($urandom_range(0, 5)) @(negedge clk);
            base = done_cnt;
            run_start(0, src, 1'b1);
            wait_done(0, base);
        end

        // Reset mid-shuffle.
        run_start(0, ident, 1'b1);
        repeat (9) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_load", load, 0);
        chk("async_rst_done", done, 0);
        chk("async_rst_arr_out", pack(arr_out), 0);
        q0.delete();
        base = done_cnt;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (150) @(negedge clk);
        chk("no_done_after_rst", done_cnt - base, 0);
        run_start(0, ident, 1'b1);
        wait_done(0, base);
        chk("fresh_start_done", done_cnt - base, 1);

        // Zero-lockup recovery.
        base = done_cnt;
        run_start(0, ident, 1'b0);
        repeat (3) @(negedge clk);
        force dut.u_lfsr.r_q = 16'h0000;
        #1;
        release dut.u_lfsr.r_q;
        @(negedge clk);
        chk("lfsr_reload", dut.u_lfsr.q, 16'hACE1);
        wait_done(0, base);
        chk("forced_done", done_cnt - base, 1);

        // Single-try build.
        for (int k = 0; k < 16; k++) src[k] = 5'h10 + 5'(k);
        for (int n = 0; n < 3; n++) begin
            base = done_cnt1;
            run_start(1, src, 1'b1);
            wait_done(1, base);
            chk("max1_done", done_cnt1 - base, 1);
        end

        chk("queues_empty", q0.size() + q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/card_shuffler.md
Name: card_shuffler

Overview:
- Shuffle stage directly upstream of the card-array register.
- Takes the 16-entry card array, performs an in-place Fisher-Yates permutation driven by a free-running 16-bit LFSR, and presents the result with a one-cycle load strobe.
- The card controller starts it on entry to the shuffle state and consumes `done` as its shuffle-complete flag.
- The LFSR runs from reset, so user timing (press of I/Sel) seeds the randomness.

Parameters:
- N_CARDS, 16, number of array entries; must be a power of two, max 16.
- CARD_W, 5, width of each entry; entries are opaque to this block.
- IDX_W, 4, index width, equal to log2(N_CARDS).
- SEED, 16'hACE1, LFSR reset value; must be non-zero.
- MAX_TRIES, 8, rejection-sampling attempts per index before falling back to no-swap.

Ports:
- clk  in  1  system clock (50 MHz domain).
- rst  in  1  asynchronous, active-low reset.
- start  in  1  level or pulse; sampled only in IDLE.
- arr_in  in  CARD_W x N_CARDS  unpacked array [0:N_CARDS-1], captured on accepted start.
- arr_out  out  CARD_W x N_CARDS  shuffled array, registered.
- busy  out  1  high from the cycle after accepted start until DONE exits.
- load  out  1  one-cycle strobe; arr_out is valid in the same cycle.
- done  out  1  one-cycle pulse, coincident with load.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; arr_out all zeros; busy=0; load=0; done=0.
  - LFSR=SEED; internal work array zero; i=N_CARDS-1; tries=0.
- LFSR:
  - 16-bit Galois, taps x^16+x^14+x^13+x^11 (mask 16'hB400).
  - Advances every clk in every state.
  - If it ever reads 0, it reloads SEED on the next cycle.
- IDLE:
  - If start=1: copy arr_in into the work array, set i=N_CARDS-1, tries=0, go to PICK.
  - Otherwise hold. arr_out keeps its last value.
- PICK (one cycle per attempt), with r = lfsr[IDX_W-1:0]:
  - r <= i: j=r, go to SWAP.
  - r > i and tries < MAX_TRIES-1: tries++, stay in PICK.
  - r > i and tries = MAX_TRIES-1: j=i (no-op swap), go to SWAP.
- SWAP (one cycle):
  - Exchange work[i] and work[j]; j=i is legal and leaves the array unchanged.
  - tries=0.
  - If i=1: go to DONE. Otherwise i--, go to PICK.
- DONE (one cycle):
  - arr_out <= work; load=1; done=1; busy=0 next cycle; go to IDLE.
  - load and done are registered outputs and are high only during the DONE cycle.
- Latency, start accepted to done:
  - Minimum 1 + 2*(N_CARDS-1) + 1 = 32 cycles.
  - Maximum 1 + (MAX_TRIES+1)*(N_CARDS-1) + 1 = 137 cycles (2.74 us at 50 MHz).
- Invariant: arr_out is always a permutation of the captured arr_in. No duplicated or lost entries under any LFSR sequence.
- start while busy: ignored, no re-capture.
- start held high continuously: a new shuffle begins the cycle after DONE returns to IDLE. Upstream must deassert start on done.
- arr_in changing while busy: no effect, since the capture happened at start.
- Reset mid-operation: immediate return to reset values; no load pulse; the partially shuffled work array is discarded.
- Index arithmetic is unsigned IDX_W bits. i never underflows because the exit condition is i=1.

Decomposition:
- Package card_pkg holds:
  - N_CARDS, CARD_W, IDX_W.
  - typedef card_t (logic [CARD_W-1:0]) and card_arr_t (card_t [0:N_CARDS-1]), for reuse by card_controller, save_cards and videoGen.
  - LFSR_MASK and the default SEED.
  - Shuffle state enum {IDLE, PICK, SWAP, DONE}.
- One sub-module: lfsr16, with ports clk, rst, q[15:0] and the zero-lockup guard. It is reusable by the random-card-pick state of the controller.

Test Plan:
- Reset, then start pulse with arr_in[k]=k (k=0..15):
  - done and load pulse exactly once, together.
  - Sorted arr_out = 0..15.
  - Latency between 32 and 137 cycles.
  - arr_out differs from identity for SEED=16'hACE1.
- Golden model: a bench LFSR mirroring SEED and the mask predicts every j.
  - arr_out matches the model exactly.
  - Repeat for 100 shuffles with random start delays; the permutation property holds each time.
- Second start asserted 5 cycles after the first:
  - Ignored; exactly one done.
  - Result equals the single-shuffle golden result.
- rst driven low 10 cycles into a shuffle:
  - busy, load and done drop asynchronously; arr_out=0.
  - No done pulse follows.
  - A fresh start then completes normally.
- Force the LFSR to 0 via hierarchical deposit:
  - Next cycle LFSR=16'hACE1.
  - The shuffle still completes with a valid permutation.
- MAX_TRIES=1 build, arr_in = 5'h10..5'h1F:
  - Completes in at most 32 cycles.
  - Output is a valid permutation of 5'h10..5'h1F.
